data_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle control unit's data-access requests (ld/sd).

---
 rtl/data_mem_pkg.sv | 9 +
 rtl/data_mem_array.sv | 22 ++
 rtl/data_mem_responder.sv | 84 ++++++++
 tb/tb_data_mem_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state encoding, width defaults and index-width helper for the data memory responder
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 64;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port synchronous RAM; rdata holds its value until the next enabled read
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int IW     = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[idx] <= wdata;
      else rdata <= mem[idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: req/ack doubleword RAM responder with fixed latency; define MISALIGN_CHECK_EN to flag misaligned accesses
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);
  localparam int IW = idx_w(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic              mis_q;
  logic              mis_in;
  logic              rd_ok;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              commit;
  logic              en;
  logic              unused_addr;
`ifdef MISALIGN_CHECK_EN
  assign mis_in = addr[2:0] != 3'd0;
`else
  assign mis_in = 1'b0;
`endif
  assign unused_addr = ^addr;
  assign commit = state == WAIT && cnt == '0;
  // gating with reset keeps a reset on the commit edge from writing the RAM
  assign en = commit && reset && !mis_q;
  assign rdata = rd_ok ? ram_rdata : '0;
  data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk(clk), .en(en), .we(we_q), .idx(idx_q), .wdata(wdata_q), .rdata(ram_rdata)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      rd_ok <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req) begin
            we_q    <= we;
            idx_q   <= addr[3 +: IW];
            wdata_q <= wdata;
            mis_q   <= mis_in;
            cnt     <= CW'(LATENCY - 1);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        WAIT:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            ack   <= 1'b1;
            err   <= mis_q;
            rd_ok <= rd_ok | (!we_q && !mis_q);
            state <= RESP;
          end
        RESP: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven checks of latency, data, wrap, reset abort and misalignment
module tb_data_mem_responder;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_v = 3'b000;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [2:0]  ack_v, busy_v, err_v;
  logic [63:0] rdata_v [3];
  int          lat [3] = '{2, 1, 4};
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );
  data_mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );
  data_mem_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_v[2]), .rdata(rdata_v[2]), .busy(busy_v[2]), .err(err_v[2])
  );
  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rd;
    logic        e;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic txn(input int k, input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] exp_rd, input logic exp_err, input string nm);
    int n = 0;
    @(negedge clk);
    req_v[k] = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req_v[k] = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    while (ack_v[k] !== 1'b1 && n < 20) begin
      chk({nm, " busy_wait"}, {63'd0, busy_v[k]}, 64'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat[k]));
    chk({nm, " busy_resp"}, {63'd0, busy_v[k]}, 64'd1);
    chk({nm, " err"}, {63'd0, err_v[k]}, {63'd0, exp_err});
    chk({nm, " rdata"}, rdata_v[k], exp_rd);
    @(posedge clk); #1;
    chk({nm, " ack_drop"}, {63'd0, ack_v[k]}, 64'd0);
    chk({nm, " idle"}, {61'd0, busy_v[k], err_v[k], 1'b0}, 64'd0);
    chk({nm, " rdata_hold"}, rdata_v[k], exp_rd);
  endtask
  task automatic rst_txn(input int m, input logic [63:0] a, input logic [63:0] d, input string nm);
    int acks = 0;
    @(negedge clk);
    req_v[0] = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    for (int i = 0; i < m; i++) begin
      @(posedge clk); #1;
      acks += int'(ack_v[0]);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    acks += int'(ack_v[0]);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks += int'(ack_v[0]);
    end
    chk({nm, " no_ack"}, 64'(acks), 64'd0);
    chk({nm, " rdata_reset"}, rdata_v[0], 64'd0);
  endtask
  initial begin
    int acks, idle_bad, accepts;
    logic prev_ack;
    tv[0] = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0};
    tv[1] = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[2] = '{1'b1, 64'h800, 64'h1, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[3] = '{1'b0, 64'h0,   64'h0, 64'h1, 1'b0};
    tv[4] = '{1'b1, 64'h20,  64'hAAAA0000_11112222, 64'h1, 1'b0};
    tv[5] = '{1'b0, 64'h20,  64'h0, 64'hAAAA0000_11112222, 1'b0};
    tv[6] = '{1'b1, 64'h13,  64'h99, 64'hAAAA0000_11112222, MIS};
    tv[7] = '{1'b0, 64'h10,  64'h0, MIS ? 64'hDEADBEEF_CAFEF00D : 64'h99, 1'b0};
    tv[8] = '{1'b0, 64'h23,  64'h0, MIS ? 64'hDEADBEEF_CAFEF00D : 64'hAAAA0000_11112222, MIS};
    tv[9] = '{1'b0, 64'h0,   64'h0, 64'h1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", {61'd0, ack_v}, 64'd0);
    chk("reset busy", {61'd0, busy_v}, 64'd0);
    chk("reset err", {61'd0, err_v}, 64'd0);
    chk("reset rdata", rdata_v[0], 64'd0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 10; i++)
      txn(0, tv[i].w, tv[i].a, tv[i].d, tv[i].rd, tv[i].e, $sformatf("vec%0d", i));
    rst_txn(0, 64'h20, 64'h55, "rst_mid_wait");
    txn(0, 1'b0, 64'h20, 64'h0, 64'hAAAA0000_11112222, 1'b0, "rd_after_rst_mid");
    rst_txn(1, 64'h20, 64'h66, "rst_commit_edge");
    txn(0, 1'b0, 64'h20, 64'h0, 64'hAAAA0000_11112222, 1'b0, "rd_after_rst_commit");
    txn(1, 1'b1, 64'h8,  64'h01234567_89ABCDEF, 64'h0, 1'b0, "l1_wr");
    txn(1, 1'b0, 64'h8,  64'h0, 64'h01234567_89ABCDEF, 1'b0, "l1_rd");
    txn(2, 1'b1, 64'h30, 64'hFEDCBA98_76543210, 64'h0, 1'b0, "l4_wr");
    txn(2, 1'b0, 64'h30, 64'h0, 64'hFEDCBA98_76543210, 1'b0, "l4_rd");
    acks = 0; idle_bad = 0; accepts = 0; prev_ack = 1'b0;
    @(negedge clk);
    req_v[0] = 1'b1; we = 1'b0; addr = 64'h20;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (prev_ack && busy_v[0]) idle_bad++;
      if (ack_v[0]) begin
        acks++;
        chk("held rdata", rdata_v[0], 64'hAAAA0000_11112222);
      end
      if (busy_v[0] && !prev_ack && !ack_v[0] && u_dut.state == data_mem_pkg::WAIT && u_dut.cnt == 1'b1)
        accepts++;
      prev_ack = ack_v[0];
    end
    req_v[0] = 1'b0;
    chk("held acks", 64'(acks), 64'd4);
    chk("held accepts", 64'(accepts), 64'd4);
    chk("held idle_gap", 64'(idle_bad), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held final idle", {63'd0, busy_v[0]}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
